// File: rtl/routing_cfg_pkg.sv
// Shared constants and FSM encoding for the routing configuration loader.
// Imported by the loader top and its shadow register.
package routing_cfg_pkg;

  localparam logic [7:0] CFG_HEADER           = 8'hA5;
  localparam int         SEL_PER_WIRE_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Byte-index width; kept at least one bit so single-byte frames still work.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/routing_cfg_shadow.sv
// Byte-addressed shadow register holding the frame being loaded, plus the
// running XOR of every payload byte (including bytes beyond SEL_W).
module routing_cfg_shadow
  import routing_cfg_pkg::*;
#(
  parameter int SEL_W  = 36,
  parameter int NBYTES = (SEL_W + 7) / 8,
  parameter int IDX_W  = idx_width(NBYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       byte_i,
  output logic [SEL_W-1:0] shadow_o,
  output logic [7:0]       xor_o
);

  logic [SEL_W-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0] byte_rep;
  logic [7:0]       xor_q, xor_d;

  // Each shadow bit b takes bit b%8 of the replicated byte when idx_i selects its lane.
  assign byte_rep = SEL_W'({NBYTES{byte_i}});

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    shadow_d = shadow_q;
    xor_d    = xor_q;
    if (clr_i) begin
      shadow_d = '0;
      xor_d    = '0;
    end else if (wr_i) begin
      xor_d = xor_q ^ byte_i;
      for (int b = 0; b < SEL_W; b++) begin
        if (idx_i == IDX_W'(b / 8)) shadow_d[b] = byte_rep[b];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shadow is a plain flop bank, so it is reset like any other register; only large RAMs go without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      xor_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      xor_q    <= xor_d;
    end
  end

  assign shadow_o = shadow_q;
  assign xor_o    = xor_q;

endmodule

// File: rtl/routing_config_loader.sv
// Loads framed switch configuration (A5, payload, XOR checksum) into a shadow
// register and commits it atomically to the routing block select bus.
module routing_config_loader
  import routing_cfg_pkg::*;
#(
  parameter int WIRE_WIDTH   = 3,
  parameter int SEL_PER_WIRE = SEL_PER_WIRE_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         cfg_data,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic                               cfg_abort,
  output logic [WIRE_WIDTH*SEL_PER_WIRE-1:0] select,
  output logic                               busy,
  output logic                               cfg_done,
  output logic                               cfg_err
);

  localparam int SEL_W  = WIRE_WIDTH * SEL_PER_WIRE;
  localparam int NBYTES = (SEL_W + 7) / 8;
  localparam int IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic             match_q;
  logic [SEL_W-1:0] select_q;
  logic             done_q, err_q;
  logic [SEL_W-1:0] shadow;
  logic [7:0]       run_xor;
  logic             sh_wr, sh_clr, chk_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // cfg_ready is high in every state that consumes a byte, so cfg_valid alone marks a transfer there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_valid && cfg_data == CFG_HEADER) state_d = ST_LOAD;
      ST_LOAD: begin
        if (cfg_abort)                          state_d = ST_IDLE;
        else if (cfg_valid && cnt_q == LAST_IDX) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cfg_abort)      state_d = ST_IDLE;
        else if (cfg_valid) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q != ST_COMMIT);
    busy      = (state_q != ST_IDLE);
    sh_wr     = (state_q == ST_LOAD)  && cfg_valid && !cfg_abort;
    chk_take  = (state_q == ST_CHECK) && cfg_valid && !cfg_abort;
    sh_clr    = (state_q == ST_COMMIT) ||
                (cfg_abort && (state_q == ST_LOAD || state_q == ST_CHECK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      match_q  <= 1'b0;
      select_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (sh_clr)     cnt_q <= '0;
      else if (sh_wr) cnt_q <= cnt_q + 1'b1;
      if (chk_take) match_q <= (cfg_data == run_xor);
      // Leaving COMMIT: publish the shadow only on a checksum match.
      if (state_q == ST_COMMIT) begin
        done_q <= match_q;
        err_q  <= !match_q;
        if (match_q) select_q <= shadow;
      end
    end
  end

  routing_cfg_shadow #(
    .SEL_W  (SEL_W),
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (sh_clr),
    .wr_i     (sh_wr),
    .idx_i    (cnt_q),
    .byte_i   (cfg_data),
    .shadow_o (shadow),
    .xor_o    (run_xor)
  );

  assign select   = select_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_routing_config_loader.sv
// Self-checking bench for routing_config_loader: a frame-level reference model
// queues expected commit outcomes, and a monitor checks each pulse and select.
module tb_routing_config_loader;

  localparam int WIRE_WIDTH = 3;
  localparam int SEL_W      = 36;
  localparam int NBYTES     = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_abort;
  logic [SEL_W-1:0] select;
  logic             busy;
  logic             cfg_done;
  logic             cfg_err;

  always #5 clk = ~clk;

  routing_config_loader #(.WIRE_WIDTH(WIRE_WIDTH), .SEL_PER_WIRE(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_abort (cfg_abort),
    .select    (select),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit               is_done;
    logic [SEL_W-1:0] sel;
    int               at_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model in frame terms: m_pos is the position within the frame
  // (-1 hunting for header, 0..NBYTES-1 payload, NBYTES checksum, NBYTES+1 commit cycle).
  int               m_pos = -1;
  logic [7:0]       m_pay[$];
  logic [SEL_W-1:0] m_sel = '0;
  bit               m_acc;
  bit               gaps = 0;
  logic [7:0]       seq[$];

  task automatic frame_result(input logic [7:0] chk);
    logic [7:0]          x;
    logic [NBYTES*8-1:0] acc;
    logic [NBYTES*8-1:0] lane;
    exp_t                e;
    x   = '0;
    acc = '0;
    foreach (m_pay[k]) begin
      x         = x ^ m_pay[k];
      lane      = '0;
      lane[7:0] = m_pay[k];
      acc       = acc | (lane << (8 * k));
    end
    // Checksum accepted at the coming edge; pulse and new select one edge after that.
    e.at_cyc = cyc + 2;
    e.is_done = (x == chk);
    if (e.is_done) m_sel = acc[SEL_W-1:0];
    e.sel = m_sel;
    sb_q.push_back(e);
  endtask

  // Present one cycle of inputs, check handshake outputs, advance the model.
  task automatic drive(input logic [7:0] d, input logic v, input logic a);
    bit exp_ready;
    cfg_data  = d;
    cfg_valid = v;
    cfg_abort = a;
    exp_ready = (m_pos != NBYTES + 1);
    check("cfg_ready", cfg_ready, exp_ready);
    check("busy", busy, m_pos >= 0);
    m_acc = v && exp_ready && !(a && m_pos >= 0 && m_pos <= NBYTES);
    if (m_pos == NBYTES + 1) begin
      m_pos = -1;
    end else if (a && m_pos >= 0) begin
      m_pos = -1;
      m_pay.delete();
    end else if (m_acc) begin
      if (m_pos < 0) begin
        if (d == 8'hA5) begin
          m_pos = 0;
          m_pay.delete();
        end
      end else if (m_pos < NBYTES) begin
        m_pay.push_back(d);
        m_pos++;
      end else begin
        frame_result(d);
        m_pos = NBYTES + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int tries;
    tries = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) drive(8'($urandom), 1'b0, 1'b0);
    end
    do begin
      drive(d, 1'b1, 1'b0);
      tries++;
    end while (!m_acc && tries < 4);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic do_reset();
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    rst_n     = 1'b0;
    m_pos     = -1;
    m_pay.delete();
    m_sel     = '0;
    #1;
    check("rst_select", select, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected outcome per pulse; otherwise select must hold.
  logic [SEL_W-1:0] sb_sel = '0;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_sel = '0;
    end else begin
      if (sb_q.size() > 0 && cyc > sb_q[0].at_cyc) begin
        mon_e = sb_q.pop_front();
        check("pulse_overdue_cycle", cyc, mon_e.at_cyc);
      end
      if (cfg_done || cfg_err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {cfg_done, cfg_err}, 2'b00);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_kind", {cfg_done, cfg_err}, mon_e.is_done ? 2'b10 : 2'b01);
          check("pulse_cycle", cyc, mon_e.at_cyc);
          check("select_at_pulse", select, mon_e.sel);
          sb_sel = mon_e.sel;
        end
      end else begin
        check("select_hold", select, sb_sel);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual_cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         kind;
    bit         aborted;
    logic [7:0] x;
    logic [7:0] b;

    do_reset();

    // Good frame, valid held high.
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h41};
    send_seq();
    idle(4);
    check("good_frame_select", select, 36'h544332211);

    // Bad checksum keeps the previous select.
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h40};
    send_seq();
    idle(4);
    check("bad_frame_select", select, 36'h544332211);

    // A5 payload byte treated as data, with random gaps.
    gaps = 1;
    seq = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
    send_seq();
    gaps = 0;
    idle(4);
    check("a5_payload_select", select, 36'h0000000A5);

    // Leading junk is discarded.
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h41};
    send_seq();
    idle(4);
    check("junk_then_good_select", select, 36'h544332211);

    // Abort together with a valid payload byte.
    seq = '{8'hA5, 8'h11, 8'h22};
    send_seq();
    drive(8'h33, 1'b1, 1'b1);
    idle(3);
    check("abort_select", select, 36'h544332211);
    seq = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
    send_seq();
    idle(4);
    check("after_abort_select", select, 36'h0000000A5);

    // Reset mid-frame, then a good frame.
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33};
    send_seq();
    do_reset();
    idle(2);
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h41};
    send_seq();
    idle(4);
    check("after_reset_select", select, 36'h544332211);

    // Randomized frames: junk, gaps, aborts, bad checksums, abort during commit.
    gaps = 1;
    for (int f = 0; f < 60; f++) begin
      kind    = $urandom_range(0, 9);
      aborted = 0;
      x       = '0;
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)));
      if (kind == 3) begin
        idle(1);
        drive(8'hA5, 1'b1, 1'b1);
      end else begin
        send_byte(8'hA5);
      end
      for (int k = 0; k < NBYTES; k++) begin
        if (kind == 0 && k == 2) begin
          drive(8'($urandom), 1'($urandom), 1'b1);
          aborted = 1;
          break;
        end
        b = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
        x = x ^ b;
        send_byte(b);
      end
      if (!aborted) begin
        send_byte(kind == 1 ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        if (kind == 2) drive(8'($urandom), 1'b1, 1'b1);
      end
      idle($urandom_range(0, 2));
    end
    gaps = 0;
    idle(6);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/routing_config_loader.md
ROUTING_CONFIG_LOADER -- requirements
Module: routing_config_loader

Interface
REQ-001 SHALL have parameter WIRE_WIDTH, default 3, number of routed wires per routing block.
REQ-002 SHALL have parameter SEL_PER_WIRE, default 12, select bits per bidirectional switch.
REQ-003 SHALL derive localparam SEL_W = WIRE_WIDTH*SEL_PER_WIRE and NBYTES = ceil(SEL_W/8).
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_data, input, 8, configuration stream byte.
REQ-007 SHALL have port cfg_valid, input, 1, cfg_data valid.
REQ-008 SHALL have port cfg_ready, output, 1, loader accepts a byte; a transfer occurs when cfg_valid and cfg_ready are both high at a clk edge.
REQ-009 SHALL have port cfg_abort, input, 1, discard the frame in progress.
REQ-010 SHALL have port select, output, SEL_W, active switch configuration driving the routing block select bus; bits [12i+11:12i] control wire i.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-012 SHALL have port cfg_done, output, 1, one-cycle pulse on successful commit.
REQ-013 SHALL have port cfg_err, output, 1, one-cycle pulse on checksum mismatch.

Function
REQ-014 SHALL implement frame format: header 0xA5, NBYTES payload bytes, 1 checksum byte equal to the XOR of all payload bytes.
REQ-015 SHALL place payload byte k at shadow bits [8k+7:8k], little-endian; bits at or above SEL_W are dropped, but still included in the checksum.
REQ-016 SHALL implement the FSM states IDLE, LOAD, CHECK and COMMIT.
REQ-017 IDLE SHALL go to LOAD on an accepted 0xA5 byte; any other accepted byte SHALL be discarded, with the FSM remaining in IDLE.
REQ-018 LOAD SHALL write each accepted byte into the shadow register, advance the byte counter, update the running XOR, and go to CHECK after byte NBYTES-1.
REQ-019 In LOAD, a 0xA5 payload byte SHALL be treated as data, not as a resync.
REQ-020 CHECK SHALL accept one byte, compare it with the running XOR, latch the result, and go to COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle with cfg_ready low, then return to IDLE.
REQ-022 On leaving COMMIT with a checksum match, select SHALL load the shadow value and cfg_done SHALL be high for the following cycle; on a mismatch, select SHALL be unchanged and cfg_err SHALL pulse instead.
REQ-023 Latency SHALL be 2 cycles from checksum-byte acceptance to the new select value, with cfg_done coincident with the new select value.
REQ-024 cfg_ready SHALL be high in IDLE, LOAD and CHECK, and low only in COMMIT; cfg_ready SHALL not depend combinationally on cfg_valid.
REQ-025 cfg_abort SHALL take priority over a simultaneous transfer: from LOAD or CHECK, go to IDLE, clear the counter and XOR, leave select unchanged, and assert no pulse.
REQ-026 cfg_abort in IDLE SHALL have no effect.
REQ-027 cfg_abort in COMMIT SHALL be ignored, and the commit SHALL complete.
REQ-028 Gaps (cfg_valid low) in any state SHALL stall the FSM without timeout.
REQ-029 select SHALL never show partial frames; it changes only on a successful commit.

Reset
REQ-030 While rst_n is low: FSM=IDLE, counter=0, XOR=0, shadow=0, select=0 (all switches open), cfg_done=0, cfg_err=0, busy=0, cfg_ready=1 after release.
REQ-031 rst_n asserted mid-frame SHALL discard the frame immediately, with no pulse after release.

Structure
REQ-032 Package routing_cfg_pkg SHALL hold CFG_HEADER=8'hA5, SEL_PER_WIRE default, and the FSM state enum.
REQ-033 Sub-module routing_cfg_shadow (byte-addressed shadow register with running XOR and clear) SHALL be instantiated once; the FSM and select register live in the top.

Verification (WIRE_WIDTH=3, NBYTES=5)
REQ-034 Stream A5 11 22 33 44 05 41 with valid held high -> select=36'h544332211 two cycles after the 41 byte is accepted, cfg_done pulses once, cfg_ready low for exactly one cycle.
REQ-035 Same frame with checksum 40 -> cfg_err pulses once, select keeps its previous value, FSM back in IDLE.
REQ-036 Bytes 00 FF then the good frame -> the leading bytes are discarded, and the result is the same as REQ-034.
REQ-037 A5 11 22, then cfg_abort high together with cfg_valid on byte 33 -> IDLE, no pulse, select unchanged; the following good frame commits correctly.
REQ-038 rst_n low after the 3rd payload byte -> select=0, busy=0; after release the good frame commits.
REQ-039 Good frame with random cfg_valid gaps and an A5 payload byte (A5 A5 00 00 00 00 A5) -> select=36'h0000000A5, cfg_done pulses once.
